// File: rtl/demux12_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer:
// input-select polarity and output-slot state encoding.
package demux12_stream_pkg;

  localparam logic SEL_A    = 1'b1;
  localparam logic SEL_B    = 1'b0;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/demux12_stream_out_slot.sv
// One-entry output buffer for a demux channel, with a wrapping count of
// words handed to the consumer.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no word held, valid low, slot can take a load
// ST_FULL  | word held on data, valid high until drained
module demux12_stream_out_slot
  import demux12_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  assign drain = (state_q == ST_FULL) && ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (drain && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    // A load in the drain cycle replaces the word with no bubble.
    if (load)  data_d  = load_data;
    if (drain) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid = (state_q == ST_FULL);
  assign data  = data_q;
  assign count = count_q;

endmodule

// File: rtl/demux12_stream.sv
// 1-to-2 registered stream demultiplexer: in_sel=1 routes to A, 0 to B.
// Each channel buffers one word, so a stalled channel never blocks the other.
module demux12_stream
  import demux12_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic a_space, b_space;
  logic accept, load_a, load_b;

  // Readiness looks only at the selected channel, keeping the channels independent.
  assign a_space  = !a_valid || a_ready;
  assign b_space  = !b_valid || b_ready;
  assign in_ready = (in_sel == SEL_A) ? a_space : b_space;

  assign accept = in_valid && in_ready;
  assign load_a = accept && (in_sel == SEL_A);
  assign load_b = accept && (in_sel == SEL_B);

  demux12_stream_out_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_a),
    .load_data(in_data),
    .ready    (a_ready),
    .valid    (a_valid),
    .data     (a_data),
    .count    (a_count)
  );

  demux12_stream_out_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_b),
    .load_data(in_data),
    .ready    (b_ready),
    .valid    (b_valid),
    .data     (b_data),
    .count    (b_count)
  );

endmodule

// File: tb/tb_demux12_stream.sv
// Bench for demux12_stream: directed steps then a random soak, all scored
// against per-channel word queues and delivery counts kept here.
module tb_demux12_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sel;
  logic       a_valid, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_ready;
  logic [7:0] b_data;
  logic [7:0] a_count, b_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] cnt_a = '0;
  logic [7:0] cnt_b = '0;

  demux12_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_sel  (in_sel),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .a_count (a_count),
    .b_count (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, score at negedge, update the reference, return at next posedge+1.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic ar, input logic br);
    logic exp_rdy;
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    @(negedge clk);
    exp_rdy = s ? (qa.size() == 0 || ar) : (qb.size() == 0 || br);
    chk("in_ready", in_ready, exp_rdy);
    chk("a_valid", a_valid, qa.size() != 0);
    chk("b_valid", b_valid, qb.size() != 0);
    if (qa.size() != 0) chk("a_data", a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", b_data, qb[0]);
    chk("a_count", a_count, cnt_a);
    chk("b_count", b_count, cnt_b);
    if (qa.size() != 0 && ar) begin void'(qa.pop_front()); cnt_a = cnt_a + 8'd1; end
    if (qb.size() != 0 && br) begin void'(qb.pop_front()); cnt_b = cnt_b + 8'd1; end
    if (v && exp_rdy) begin
      if (s) qa.push_back(d);
      else   qb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c0;
    logic [7:0] start;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    #3;
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_a_data", a_data, 8'h00);
    chk("rst_b_data", b_data, 8'h00);
    chk("rst_a_count", a_count, 8'h00);
    chk("rst_b_count", b_count, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed routing
    step(1'b1, 1'b1, 8'h11, 1'b1, 1'b1);
    chk("route_a_valid", a_valid, 1'b1);
    chk("route_a_data", a_data, 8'h11);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
    chk("route_b_data", b_data, 8'h22);
    chk("route_a_count", a_count, 8'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("route_b_count", b_count, 8'd1);
    chk("route_a_empty", a_valid, 1'b0);

    // Back-pressure isolation
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    chk("bp_a_data", a_data, 8'h33);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h77; a_ready = 1'b0;
    #1 chk("bp_ready_a_stalled", in_ready, 1'b0);
    in_sel = 1'b0; in_data = 8'h44;
    #1 chk("bp_ready_b_free", in_ready, 1'b1);
    step(1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
    chk("bp_b_data", b_data, 8'h44);
    chk("bp_a_hold", a_data, 8'h33);
    chk("bp_a_valid", a_valid, 1'b1);

    // Simultaneous drain and load
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("sdl_a_data55", a_data, 8'h55);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h66; a_ready = 1'b1;
    #1 chk("sdl_ready", in_ready, 1'b1);
    c0 = cnt_a;
    step(1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
    chk("sdl_a_valid", a_valid, 1'b1);
    chk("sdl_a_data66", a_data, 8'h66);
    chk("sdl_a_count", a_count, c0 + 8'd1);

    // Streaming and counter wrap
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    start = cnt_a;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = 8'(i) ^ 8'hA5;
      step(1'b1, 1'b1, w, 1'b1, 1'b1);
      chk("stream_word", a_data, w);
    end
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("stream_wrap", a_count, start);
    chk("stream_empty", a_valid, 1'b0);

    // Reset mid-operation
    step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", a_valid, 1'b0);
    chk("mid_rst_b_valid", b_valid, 1'b0);
    chk("mid_rst_a_data", a_data, 8'h00);
    chk("mid_rst_b_data", b_data, 8'h00);
    chk("mid_rst_a_count", a_count, 8'h00);
    chk("mid_rst_b_count", b_count, 8'h00);
    #1 rst_n = 1'b1;
    qa.delete(); qb.delete(); cnt_a = '0; cnt_b = '0;
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_a_valid", a_valid, 1'b1);
    chk("post_rst_a_data", a_data, 8'h5A);

    // Random soak
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'(($urandom % 4) != 0), 1'(($urandom % 3) != 0));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("soak_a_drained", a_valid, 1'b0);
    chk("soak_b_drained", b_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
